// File: rtl/alu_cmd_issuer.sv
// Command-side initiator for the ALU execution units: issues one operation on the shared
// operand bus, pulses the selected unit enable, then returns the unit result or a timeout error.
module alu_cmd_issuer #(
    parameter int alu_width = 16,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [alu_width-1:0] cmd_a,
    input  logic [alu_width-1:0] cmd_b,
    input  logic [3:0]           cmd_op,
    output logic [alu_width-1:0] A,
    output logic [alu_width-1:0] B,
    output logic [1:0]           alu_fun,
    output logic                 arith_enable,
    output logic                 logic_enable,
    output logic                 cmp_enable,
    output logic                 shift_enable,
    input  logic [alu_width-1:0] unit_out,
    input  logic                 unit_flag,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [alu_width-1:0] rsp_data,
    output logic                 rsp_err,
    output logic                 busy
);

    localparam int cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(TIMEOUT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [1:0]       sel_r;
    logic [cnt_w-1:0] cnt_r;
    logic             wait_done_s;

    assign wait_done_s = unit_flag || (cnt_r == cnt_last);

    // Next-state decode of the issue/wait/response sequence.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (wait_done_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand bus, unit select, wait counter and response capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            A        <= {alu_width{1'b0}};
            B        <= {alu_width{1'b0}};
            alu_fun  <= 2'b00;
            sel_r    <= 2'b00;
            cnt_r    <= {cnt_w{1'b0}};
            rsp_data <= {alu_width{1'b0}};
            rsp_err  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (cmd_valid) begin
                        A       <= cmd_a;
                        B       <= cmd_b;
                        alu_fun <= cmd_op[1:0];
                        sel_r   <= cmd_op[3:2];
                    end
                end
                ISSUE: begin
                    cnt_r <= {cnt_w{1'b0}};
                end
                WAIT: begin
                    // A flag arriving on the last allowed cycle still counts as an answer.
                    if (unit_flag) begin
                        rsp_data <= unit_out;
                        rsp_err  <= 1'b0;
                    end else if (cnt_r == cnt_last) begin
                        rsp_data <= {alu_width{1'b0}};
                        rsp_err  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + cnt_w'(1);
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    // Enables and handshake flags decode straight from the state register so reset clears them at once.
    assign cmd_ready    = (state_r == IDLE);
    assign busy         = (state_r != IDLE);
    assign rsp_valid    = (state_r == RESP);
    assign arith_enable = (state_r == ISSUE) && (sel_r == 2'b00);
    assign logic_enable = (state_r == ISSUE) && (sel_r == 2'b01);
    assign cmp_enable   = (state_r == ISSUE) && (sel_r == 2'b10);
    assign shift_enable = (state_r == ISSUE) && (sel_r == 2'b11);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: directed vector table, hand-written corner
// sequences and randomized commands against a transaction-level reference model.
module tb_alu_cmd_issuer;

    localparam int W  = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_b = '0;
    logic [3:0]    cmd_op = '0;
    logic [W-1:0]  A, B;
    logic [1:0]    alu_fun;
    logic          arith_enable, logic_enable, cmp_enable, shift_enable;
    logic [W-1:0]  unit_out = '0;
    logic          unit_flag = 1'b0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_data;
    logic          rsp_err;
    logic          busy;

    int errors = 0;
    int checks = 0;

    // unit model controls: answer d WAIT cycles after the enable (0 = never)
    int           m_delay = 1;
    bit           m_ovr_en = 1'b0;
    logic [W-1:0] m_ovr = '0;
    bit           m_armed = 1'b0;
    int           m_n = 0;
    int           m_unit = 0;

    alu_cmd_issuer #(.alu_width(W), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .A(A), .B(B), .alu_fun(alu_fun),
        .arith_enable(arith_enable), .logic_enable(logic_enable),
        .cmp_enable(cmp_enable), .shift_enable(shift_enable),
        .unit_out(unit_out), .unit_flag(unit_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] unit_result(input int unit, input logic [W-1:0] a,
                                                 input logic [W-1:0] b, input logic [1:0] fun);
        case (unit)
            0:       return a + b;
            1:       return a ^ b;
            2:       return (a < b) ? 16'd1 : 16'd0;
            default: return a >> (int'(fun) + 1);
        endcase
    endfunction

    // Execution-unit model: registers a result d cycles after seeing its enable.
    always @(negedge clk) begin
        if (rst) begin
            m_armed   = 1'b0;
            unit_flag = 1'($urandom);
            unit_out  = 16'($urandom);
        end else if (arith_enable || logic_enable || cmp_enable || shift_enable) begin
            m_armed   = 1'b1;
            m_n       = 0;
            m_unit    = arith_enable ? 0 : logic_enable ? 1 : cmp_enable ? 2 : 3;
            unit_flag = 1'b0;
            unit_out  = 16'($urandom);
        end else if (m_armed) begin
            m_n = m_n + 1;
            if (m_n == m_delay) begin
                unit_flag = 1'b1;
                unit_out  = m_ovr_en ? m_ovr : unit_result(m_unit, A, B, alu_fun);
                m_armed   = 1'b0;
            end else begin
                unit_flag = 1'b0;
                unit_out  = 16'($urandom);
            end
        end else begin
            unit_flag = 1'b0;
            unit_out  = 16'($urandom);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic en_of(input int unit);
        case (unit)
            0:       return arith_enable;
            1:       return logic_enable;
            2:       return cmp_enable;
            default: return shift_enable;
        endcase
    endfunction

    // Runs one command from an IDLE negedge through its response handshake.
    task automatic do_cmd(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                          input int d, input bit ovr_en, input logic [W-1:0] ovr, input int hold,
                          input logic [W-1:0] ed, input logic ee, input int el,
                          input bit pend, input logic [W-1:0] pa, input logic [W-1:0] pb,
                          input logic [3:0] pop);
        int k, hits, others, bad, waitc, unit;
        unit  = int'(op[3:2]);
        waitc = 0;
        while (!cmd_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        chk("cmd_ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
        m_delay = d; m_ovr_en = ovr_en; m_ovr = ovr;
        cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_op = op;
        @(negedge clk);
        if (pend) begin
            cmd_a = pa; cmd_b = pb; cmd_op = pop;
        end else begin
            cmd_valid = 1'b0;
            cmd_a = 16'($urandom); cmd_b = 16'($urandom); cmd_op = 4'($urandom);
        end
        k = 1; hits = 0; others = 0; bad = 0;
        while (!rsp_valid && k < 40) begin
            for (int u = 0; u < 4; u++) begin
                if (en_of(u)) begin
                    if (u == unit) hits++;
                    else others++;
                end
            end
            if (cmd_ready || !busy) bad++;
            @(negedge clk);
            k++;
        end
        chk("rsp_latency", 64'(k - 1), 64'(el));
        chk("enable_pulses", 64'(hits), 64'd1);
        chk("other_enables", 64'(others), 64'd0);
        chk("busy_not_ready", 64'(bad), 64'd0);
        chk("rsp_data", {48'd0, rsp_data}, {48'd0, ed});
        chk("rsp_err", {63'd0, rsp_err}, {63'd0, ee});
        chk("bus_hold", {30'd0, A, B, alu_fun}, {30'd0, a, b, op[1:0]});
        bad = 0;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            if (!rsp_valid || rsp_data !== ed || rsp_err !== ee || cmd_ready) bad++;
        end
        chk("backpressure_stable", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", {63'd0, rsp_valid}, 64'd0);
        chk("idle_after_rsp", {62'd0, cmd_ready, busy}, 64'd2);
        if (pend) chk("no_accept_on_handshake", {48'd0, A}, {48'd0, a});
    endtask

    typedef struct {
        logic [W-1:0] a, b;
        logic [3:0]   op;
        int           d;
        bit           ovr_en;
        logic [W-1:0] ovr;
        int           hold;
        logic [W-1:0] ed;
        logic         ee;
        int           el;
    } vec_t;

    vec_t vecs[6];
    logic [W-1:0] ra, rb, red;
    logic [3:0]   rop;
    logic         ree;
    int           rd, rel, cnt_bad;

    initial begin
        vecs[0] = '{16'h0006, 16'h0000, 4'b1100, 1, 1'b0, 16'h0000, 0, 16'h0003, 1'b0, 2};
        vecs[1] = '{16'h1234, 16'h1111, 4'b0010, 0, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 9};
        vecs[2] = '{16'h0007, 16'h0009, 4'b0100, 8, 1'b1, 16'hBEEF, 0, 16'hBEEF, 1'b0, 9};
        vecs[3] = '{16'h00F0, 16'h0F0F, 4'b0101, 3, 1'b0, 16'h0000, 2, 16'h0FFF, 1'b0, 4};
        vecs[4] = '{16'h0005, 16'h0009, 4'b1000, 2, 1'b0, 16'h0000, 1, 16'h0001, 1'b0, 3};
        vecs[5] = '{16'hFFFF, 16'h0002, 4'b0011, 1, 1'b0, 16'h0000, 0, 16'h0001, 1'b0, 2};

        // reset with random inputs
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'($urandom); cmd_a = 16'($urandom); cmd_b = 16'($urandom);
            cmd_op = 4'($urandom); rsp_ready = 1'($urandom);
            @(negedge clk);
            chk("reset_state",
                {6'd0, cmd_ready, rsp_valid, rsp_data, rsp_err, busy, A, B, alu_fun,
                 arith_enable, logic_enable, cmp_enable, shift_enable},
                {6'd0, 1'b1, 1'b0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 2'd0, 4'd0});
        end
        cmd_valid = 1'b0; rsp_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            do_cmd(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].d, vecs[i].ovr_en, vecs[i].ovr,
                   vecs[i].hold, vecs[i].ed, vecs[i].ee, vecs[i].el, 1'b0, 16'd0, 16'd0, 4'd0);
        end

        // backpressure with a second command pending
        do_cmd(16'h0010, 16'h0020, 4'b0000, 1, 1'b0, 16'd0, 5, 16'h0030, 1'b0, 2,
               1'b1, 16'h0100, 16'h0003, 4'b1101);
        do_cmd(16'h0100, 16'h0003, 4'b1101, 1, 1'b0, 16'd0, 0, 16'h0040, 1'b0, 2,
               1'b0, 16'd0, 16'd0, 4'd0);

        // reset while the enable is high
        m_delay = 0;
        cmd_valid = 1'b1; cmd_a = 16'h0001; cmd_b = 16'h0002; cmd_op = 4'b1010;
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("issue_enable", {63'd0, cmp_enable}, 64'd1);
        rst = 1'b1;
        #1;
        chk("enable_drop_on_rst", {60'd0, arith_enable, logic_enable, cmp_enable, shift_enable}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // reset mid-WAIT, then a normal arith command
        cmd_valid = 1'b1; cmd_a = 16'h0AAA; cmd_b = 16'h0555; cmd_op = 4'b0010;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_wait", {60'd0, rsp_valid, busy, cmd_ready, arith_enable | logic_enable | cmp_enable | shift_enable},
            {60'd0, 1'b0, 1'b0, 1'b1, 1'b0});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt_bad = 0;
        repeat (12) begin
            @(negedge clk);
            if (rsp_valid || busy) cnt_bad++;
        end
        chk("no_rsp_after_rst", 64'(cnt_bad), 64'd0);
        do_cmd(16'd100, 16'd23, 4'b0001, 1, 1'b0, 16'd0, 0, 16'd123, 1'b0, 2,
               1'b0, 16'd0, 16'd0, 4'd0);

        // randomized commands against the reference model
        for (int i = 0; i < 30; i++) begin
            ra  = 16'($urandom); rb = 16'($urandom); rop = 4'($urandom);
            rd  = int'($urandom_range(0, TO + 1));
            if (rd >= 1 && rd <= TO) begin
                red = unit_result(int'(rop[3:2]), ra, rb, rop[1:0]);
                ree = 1'b0;
                rel = rd + 1;
            end else begin
                red = 16'd0;
                ree = 1'b1;
                rel = TO + 1;
            end
            do_cmd(ra, rb, rop, rd, 1'b0, 16'd0, int'($urandom_range(0, 3)), red, ree, rel,
                   1'b0, 16'd0, 16'd0, 4'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
